opcode_decode_stage: RTL and testbench

- Registered, parametrised successor to the combinational opcode decoder.
- Takes a fetched instruction word, extracts the OP_W-bit opcode and decodes it to a one-hot vector, qualified by a legal-opcode mask.
- Also sub-decodes the R-type ALU op field, flags illegal opcodes, and holds the result in a valid/ready pipeline register between fetch and execute.
- Maintains a saturating illegal-opcode counter and a sticky error flag for debug readout.

---
 rtl/opcode_decode_stage_pkg.sv | 34 +++
 rtl/opcode_onehot_decode.sv | 26 ++
 rtl/opcode_decode_stage.sv | 128 ++++++++++++
 tb/tb_opcode_decode_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_decode_stage_pkg.sv
// Shared definitions for the registered opcode decode stage.
// Holds the opcode map, the default legal-opcode mask and the default
// field geometry of the instruction word.
package opcode_decode_stage_pkg;

  // Default field geometry
  localparam int unsigned DEF_INSN_W  = 32;
  localparam int unsigned DEF_OP_W    = 5;
  localparam int unsigned DEF_ALU_LSB = 2;
  localparam int unsigned DEF_ALU_W   = 5;
  localparam int unsigned DEF_CNT_W   = 8;

  // Opcode map
  localparam int unsigned OP_R     = 0;
  localparam int unsigned OP_J     = 1;
  localparam int unsigned OP_BNE   = 2;
  localparam int unsigned OP_JAL   = 3;
  localparam int unsigned OP_JR    = 4;
  localparam int unsigned OP_ADDI  = 5;
  localparam int unsigned OP_BLT   = 6;
  localparam int unsigned OP_SW    = 7;
  localparam int unsigned OP_LW    = 8;
  localparam int unsigned OP_ISW   = 9;
  localparam int unsigned OP_ILW   = 10;
  localparam int unsigned OP_RI    = 11;
  localparam int unsigned OP_RTICK = 12;
  localparam int unsigned OP_RSEC  = 13;
  localparam int unsigned OP_SETX  = 21;
  localparam int unsigned OP_BEX   = 22;

  // Opcodes 0..13 plus setx and bex
  localparam logic [31:0] DEFAULT_LEGAL_MASK = 32'h0060_3FFF;

endpackage

// File: rtl/opcode_onehot_decode.sv
// Combinational opcode decoder.
// Ports:
//   op      - raw opcode
//   onehot  - one-hot opcode, qualified by LEGAL_MASK (all-zero if illegal)
//   illegal - opcode not present in LEGAL_MASK
module opcode_onehot_decode
  import opcode_decode_stage_pkg::*;
#(
  parameter int unsigned         OP_W       = DEF_OP_W,
  parameter logic [2**OP_W-1:0]  LEGAL_MASK = DEFAULT_LEGAL_MASK
) (
  input  logic [OP_W-1:0]    op,
  output logic [2**OP_W-1:0] onehot,
  output logic               illegal
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < 2**OP_W; k++) begin
      onehot[k] = (op == OP_W'(k)) & LEGAL_MASK[k];
    end
  end

  assign illegal = ~LEGAL_MASK[op];

endmodule

// File: rtl/opcode_decode_stage.sv
// Registered opcode decode stage between fetch and execute.
// Decodes the opcode of an incoming instruction to a legality-qualified
// one-hot vector, extracts the R-type ALU field and holds the result in a
// single-entry valid/ready register. Also keeps a saturating count and a
// sticky flag of accepted illegal opcodes.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   in_valid/in_ready     - upstream handshake; in_insn is the fetched word
//   flush                 - drop held and incoming instruction
//   out_valid/out_ready   - downstream handshake
//   out_onehot/opcode/aluop/insn/illegal - registered decode payload
//   clear_err             - clear illegal_count and illegal_sticky
//   illegal_count/sticky  - debug readout of illegal-opcode tracking
module opcode_decode_stage
  import opcode_decode_stage_pkg::*;
#(
  parameter int unsigned        INSN_W     = DEF_INSN_W,
  parameter int unsigned        OP_W       = DEF_OP_W,
  parameter int unsigned        ALU_LSB    = DEF_ALU_LSB,
  parameter int unsigned        ALU_W      = DEF_ALU_W,
  parameter logic [2**OP_W-1:0] LEGAL_MASK = DEFAULT_LEGAL_MASK,
  parameter int unsigned        CNT_W      = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSN_W-1:0]   in_insn,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**OP_W-1:0]  out_onehot,
  output logic [OP_W-1:0]     out_opcode,
  output logic [ALU_W-1:0]    out_aluop,
  output logic [INSN_W-1:0]   out_insn,
  output logic                out_illegal,
  input  logic                clear_err,
  output logic [CNT_W-1:0]    illegal_count,
  output logic                illegal_sticky
);

  localparam int unsigned NOPS = 2**OP_W;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  // Input-side decode
  logic [OP_W-1:0]  in_op;
  logic [NOPS-1:0]  in_onehot;
  logic             in_illegal;
  logic [ALU_W-1:0] in_aluop;
  logic             accept;

  assign in_op    = in_insn[INSN_W-1 -: OP_W];
  assign in_aluop = (in_op == '0) ? in_insn[ALU_LSB +: ALU_W] : '0;

  opcode_onehot_decode #(
    .OP_W       (OP_W),
    .LEGAL_MASK (LEGAL_MASK)
  ) u_decode (
    .op      (in_op),
    .onehot  (in_onehot),
    .illegal (in_illegal)
  );

  // in_ready depends only on state, reset and out_ready, never on in_valid
  assign out_valid = (state_q == StFull);
  assign in_ready  = ~reset & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end
  end

  // Error tracking: clear applies first so a same-cycle illegal accept still counts
  logic [CNT_W-1:0] cnt_d;
  logic             sticky_d;

  always_comb begin
    cnt_d    = illegal_count;
    sticky_d = illegal_sticky;
    if (clear_err) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (accept && in_illegal) begin
      sticky_d = 1'b1;
      if (cnt_d != CntMax) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StEmpty;
      out_onehot     <= '0;
      out_opcode     <= '0;
      out_aluop      <= '0;
      out_insn       <= '0;
      out_illegal    <= 1'b0;
      illegal_count  <= '0;
      illegal_sticky <= 1'b0;
    end else begin
      state_q        <= state_d;
      illegal_count  <= cnt_d;
      illegal_sticky <= sticky_d;
      // Payload is only qualified by out_valid, so it is left alone on flush/drain
      if (accept) begin
        out_onehot  <= in_onehot;
        out_opcode  <= in_op;
        out_aluop   <= in_aluop;
        out_insn    <= in_insn;
        out_illegal <= in_illegal;
      end
    end
  end

endmodule

// File: tb/tb_opcode_decode_stage.sv
module tb_opcode_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_onehot;
  logic [4:0]  out_opcode;
  logic [4:0]  out_aluop;
  logic [31:0] out_insn;
  logic        out_illegal;
  logic        clear_err;
  logic [7:0]  illegal_count;
  logic        illegal_sticky;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  opcode_decode_stage dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_insn        (in_insn),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_onehot     (out_onehot),
    .out_opcode     (out_opcode),
    .out_aluop      (out_aluop),
    .out_insn       (out_insn),
    .out_illegal    (out_illegal),
    .clear_err      (clear_err),
    .illegal_count  (illegal_count),
    .illegal_sticky (illegal_sticky)
  );

  // Advance one edge and settle 1 time unit past it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_insn = 32'h2800_0000; flush = 1'b0;
    out_ready = 1'b1; clear_err = 1'b0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_onehot !== 32'h0) begin n_err++; $display("FAIL reset_onehot got %h want 0", out_onehot); end
    n_cmp++; if (out_insn !== 32'h0) begin n_err++; $display("FAIL reset_insn got %h want 0", out_insn); end
    n_cmp++; if (illegal_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", illegal_count); end
    n_cmp++; if (illegal_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky got %b want 0", illegal_sticky); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic_decode();
    in_valid = 1'b1; in_insn = 32'h2800_0000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b want 1", out_valid); end
    n_cmp++; if (out_onehot !== 32'h0000_0020) begin n_err++; $display("FAIL addi_onehot got %h want 00000020", out_onehot); end
    n_cmp++; if (out_opcode !== 5'd5) begin n_err++; $display("FAIL addi_opcode got %0d want 5", out_opcode); end
    n_cmp++; if (out_aluop !== 5'd0) begin n_err++; $display("FAIL addi_aluop got %0d want 0", out_aluop); end
    n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL addi_illegal got %b want 0", out_illegal); end
    n_cmp++; if (out_insn !== 32'h2800_0000) begin n_err++; $display("FAIL addi_insn got %h want 28000000", out_insn); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain got %b want 0", out_valid); end
  endtask

  // Back-to-back stream, one instruction per cycle
  task automatic test_back_to_back();
    in_valid = 1'b1; out_ready = 1'b1;
    in_insn = 32'h0000_000C;
    step();
    n_cmp++; if (out_onehot !== 32'h0000_0001) begin n_err++; $display("FAIL r_onehot got %h want 00000001", out_onehot); end
    n_cmp++; if (out_aluop !== 5'd3) begin n_err++; $display("FAIL r_aluop got %0d want 3", out_aluop); end
    in_insn = 32'hB000_00FF;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bex_valid got %b want 1", out_valid); end
    n_cmp++; if (out_onehot !== 32'h0040_0000) begin n_err++; $display("FAIL bex_onehot got %h want 00400000", out_onehot); end
    n_cmp++; if (out_aluop !== 5'd0) begin n_err++; $display("FAIL bex_aluop got %0d want 0", out_aluop); end
    n_cmp++; if (out_opcode !== 5'd22) begin n_err++; $display("FAIL bex_opcode got %0d want 22", out_opcode); end
    in_insn = 32'hA800_0000;
    step();
    n_cmp++; if (out_onehot !== 32'h0020_0000) begin n_err++; $display("FAIL setx_onehot got %h want 00200000", out_onehot); end
    in_insn = 32'h6800_0000;
    step();
    n_cmp++; if (out_onehot !== 32'h0000_2000) begin n_err++; $display("FAIL rsec_onehot got %h want 00002000", out_onehot); end
    n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL rsec_illegal got %b want 0", out_illegal); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; out_ready = 1'b1; in_insn = 32'h7000_0000;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_onehot !== 32'h0) begin n_err++; $display("FAIL ill14_onehot got %h want 0", out_onehot); end
    n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL ill14_flag got %b want 1", out_illegal); end
    n_cmp++; if (illegal_count !== 8'd1) begin n_err++; $display("FAIL ill14_count got %0d want 1", illegal_count); end
    n_cmp++; if (illegal_sticky !== 1'b1) begin n_err++; $display("FAIL ill14_sticky got %b want 1", illegal_sticky); end
    in_valid = 1'b1;
    for (int i = 0; i < 253; i++) begin
      in_insn = (i[0]) ? 32'hF800_0000 : 32'h7000_0000;
      step();
    end
    n_cmp++; if (illegal_count !== 8'd254) begin n_err++; $display("FAIL ill_count_254 got %0d want 254", illegal_count); end
    in_insn = 32'hF800_0000;
    step();
    n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL ill31_flag got %b want 1", out_illegal); end
    n_cmp++; if (illegal_count !== 8'd255) begin n_err++; $display("FAIL ill_count_255 got %0d want 255", illegal_count); end
    for (int i = 0; i < 46; i++) step();
    n_cmp++; if (illegal_count !== 8'd255) begin n_err++; $display("FAIL ill_saturate got %0d want 255", illegal_count); end
    in_valid = 1'b0; clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_cmp++; if (illegal_count !== 8'd0) begin n_err++; $display("FAIL clear_count got %0d want 0", illegal_count); end
    n_cmp++; if (illegal_sticky !== 1'b0) begin n_err++; $display("FAIL clear_sticky got %b want 0", illegal_sticky); end
    // Clear and illegal accept together: the new illegal instruction still counts
    in_valid = 1'b1; in_insn = 32'h7800_0000; clear_err = 1'b1;
    step();
    in_valid = 1'b1; in_insn = 32'h7000_0000; clear_err = 1'b1;
    step();
    clear_err = 1'b0; in_valid = 1'b0;
    n_cmp++; if (illegal_count !== 8'd1) begin n_err++; $display("FAIL clear_and_ill_count got %0d want 1", illegal_count); end
    n_cmp++; if (illegal_sticky !== 1'b1) begin n_err++; $display("FAIL clear_and_ill_sticky got %b want 1", illegal_sticky); end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_onehot;
    in_valid = 1'b1; out_ready = 1'b1; in_insn = 32'h2800_0001;
    step();
    out_ready = 1'b0; in_insn = 32'h0000_0010;
    held_onehot = 32'h0000_0020;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_insn !== 32'h2800_0001 || out_onehot !== held_onehot)
        begin n_err++; $display("FAIL bp_hold[%0d] got v=%b insn=%h oh=%h want v=1 insn=28000001 oh=%h",
                                i, out_valid, out_insn, out_onehot, held_onehot); end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_insn !== 32'h0000_0010) begin n_err++;
      $display("FAIL bp_release got v=%b insn=%h want v=1 insn=00000010", out_valid, out_insn); end
    n_cmp++; if (out_aluop !== 5'd4) begin n_err++; $display("FAIL bp_release_aluop got %0d want 4", out_aluop); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    // Count is 1 coming in from test_illegal
    in_valid = 1'b1; out_ready = 1'b0; in_insn = 32'h3000_0000;
    step();
    in_insn = 32'h7000_0000; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_cmp++; if (illegal_count !== 8'd1) begin n_err++; $display("FAIL flush_count got %0d want 1", illegal_count); end
    n_cmp++; if (out_insn !== 32'h3000_0000) begin n_err++; $display("FAIL flush_payload got %h want 30000000", out_insn); end
    // Flush while held and stalled, with no input
    in_valid = 1'b1; in_insn = 32'h0800_0000; out_ready = 1'b0;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_held got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; in_insn = 32'h7000_0000;
    step();
    n_cmp++; if (out_illegal !== 1'b1 || illegal_count !== 8'd2) begin n_err++;
      $display("FAIL pre_reset got ill=%b cnt=%0d want ill=1 cnt=2", out_illegal, illegal_count); end
    reset = 1'b1; in_insn = 32'h2800_0000;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_in_ready_comb got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_onehot !== 32'h0 || out_opcode !== 5'd0 || out_aluop !== 5'd0 ||
                 out_insn !== 32'h0 || out_illegal !== 1'b0) begin n_err++;
      $display("FAIL mid_reset_outs got v=%b oh=%h op=%0d alu=%0d insn=%h ill=%b want all 0",
               out_valid, out_onehot, out_opcode, out_aluop, out_insn, out_illegal); end
    n_cmp++; if (illegal_count !== 8'd0 || illegal_sticky !== 1'b0) begin n_err++;
      $display("FAIL mid_reset_err got cnt=%0d sticky=%b want 0 0", illegal_count, illegal_sticky); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_in_ready got %b want 0", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_accept got %b want 0", out_valid); end
    reset = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_onehot !== 32'h0000_0020) begin n_err++;
      $display("FAIL post_reset_accept got v=%b oh=%h want v=1 oh=00000020", out_valid, out_onehot); end
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
